// File: rtl/host_pkg.sv
// Opcode encodings shared by the host request queue and the AXI-lite control bridge.
package host_pkg;

    localparam logic HOST_OP_READ  = 1'b0;
    localparam logic HOST_OP_WRITE = 1'b1;

endpackage

// File: rtl/host_sync_fifo.sv
// Single-clock circular FIFO: head is visible on dout, no bypass from din to dout.
module host_sync_fifo #(
    parameter int WIDTH = 41,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // A full queue refuses pushes even when a pop frees a slot in the same cycle.
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/host_req_queue.sv
// Host request queue with read flow control and a one-deep response holding register.
// Optional event trace: define HOST_REQ_QUEUE_TRACE_EN.
module host_req_queue
    import host_pkg::*;
#(
    parameter int HOST_ADDR_BITS = 8,
    parameter int HOST_DATA_BITS = 32,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      dpi_req_valid,
    input  logic                      dpi_req_opcode,
    input  logic [HOST_ADDR_BITS-1:0] dpi_req_addr,
    input  logic [HOST_DATA_BITS-1:0] dpi_req_value,
    output logic                      dpi_req_deq,
    output logic                      dpi_resp_valid,
    input  logic                      dpi_resp_ready,
    output logic [HOST_DATA_BITS-1:0] dpi_resp_bits,
    output logic                      host_req_valid,
    output logic                      host_req_opcode,
    output logic [HOST_ADDR_BITS-1:0] host_req_addr,
    output logic [HOST_DATA_BITS-1:0] host_req_value,
    input  logic                      host_req_deq,
    input  logic                      host_resp_valid,
    input  logic [HOST_DATA_BITS-1:0] host_resp_bits
);

    typedef struct packed {
        logic                      opcode;
        logic [HOST_ADDR_BITS-1:0] addr;
        logic [HOST_DATA_BITS-1:0] value;
    } req_entry_t;

    localparam int ENTRY_W = $bits(req_entry_t);

    req_entry_t                push_entry;
    req_entry_t                head;
    logic [ENTRY_W-1:0]        head_raw;
    logic                      q_full;
    logic                      q_empty;
    logic                      pop;
    logic                      head_is_read;
    logic                      issue_read;
    logic                      capture;
    logic                      rd_pending;
    logic                      resp_full;
    logic [HOST_DATA_BITS-1:0] resp_bits;

    assign dpi_req_deq = dpi_req_valid & ~q_full & ~reset;
    assign push_entry  = '{opcode: dpi_req_opcode, addr: dpi_req_addr, value: dpi_req_value};

    host_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (dpi_req_deq),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head_raw),
        .full  (q_full),
        .empty (q_empty)
    );

    assign head         = q_empty ? '0 : req_entry_t'(head_raw);
    assign head_is_read = (head.opcode == HOST_OP_READ);

    // A read waits until the previous read has returned and the host has taken its data.
    assign host_req_valid  = ~q_empty & ~(head_is_read & (rd_pending | resp_full));
    assign host_req_opcode = head.opcode;
    assign host_req_addr   = head.addr;
    assign host_req_value  = head.value;

    assign pop        = host_req_deq & ~q_empty;
    assign issue_read = pop & head_is_read;
    assign capture    = host_resp_valid & rd_pending;

    assign dpi_resp_valid = resp_full;
    assign dpi_resp_bits  = resp_bits;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_pending <= 1'b0;
            resp_full  <= 1'b0;
            resp_bits  <= '0;
        end else begin
            if (issue_read)           rd_pending <= 1'b1;
            else if (host_resp_valid) rd_pending <= 1'b0;

            if (capture) begin
                resp_bits <= host_resp_bits;
                resp_full <= 1'b1;
            end else if (dpi_resp_ready & resp_full) begin
                resp_full <= 1'b0;
            end
        end
    end

`ifdef HOST_REQ_QUEUE_TRACE_EN
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (dpi_req_deq)
                $display("enq op:%b addr:%x data:%x", dpi_req_opcode, dpi_req_addr, dpi_req_value);
            if (pop)
                $display("deq op:%b addr:%x", head.opcode, head.addr);
            if (capture)
                $display("resp:%x", host_resp_bits);
            if (host_resp_valid & ~rd_pending)
                $display("stray resp");
        end
    end
`else
    // Trace disabled: the datapath and control above are unchanged.
`endif

endmodule

// File: tb/tb_host_req_queue.sv
// Self-checking bench for host_req_queue: per-cycle model with request and response scoreboards.
module tb_host_req_queue;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          dpi_req_valid;
    logic          dpi_req_opcode;
    logic [AW-1:0] dpi_req_addr;
    logic [DW-1:0] dpi_req_value;
    logic          dpi_req_deq;
    logic          dpi_resp_valid;
    logic          dpi_resp_ready;
    logic [DW-1:0] dpi_resp_bits;
    logic          host_req_valid;
    logic          host_req_opcode;
    logic [AW-1:0] host_req_addr;
    logic [DW-1:0] host_req_value;
    logic          host_req_deq;
    logic          host_resp_valid;
    logic [DW-1:0] host_resp_bits;

    host_req_queue #(
        .HOST_ADDR_BITS (AW),
        .HOST_DATA_BITS (DW),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .dpi_req_valid   (dpi_req_valid),
        .dpi_req_opcode  (dpi_req_opcode),
        .dpi_req_addr    (dpi_req_addr),
        .dpi_req_value   (dpi_req_value),
        .dpi_req_deq     (dpi_req_deq),
        .dpi_resp_valid  (dpi_resp_valid),
        .dpi_resp_ready  (dpi_resp_ready),
        .dpi_resp_bits   (dpi_resp_bits),
        .host_req_valid  (host_req_valid),
        .host_req_opcode (host_req_opcode),
        .host_req_addr   (host_req_addr),
        .host_req_value  (host_req_value),
        .host_req_deq    (host_req_deq),
        .host_resp_valid (host_resp_valid),
        .host_resp_bits  (host_resp_bits)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic          op;
        logic [AW-1:0] addr;
        logic [DW-1:0] val;
    } ent_t;

    ent_t          exp_q[$];
    logic [DW-1:0] resp_q[$];
    logic          m_pend;
    logic          m_full;
    logic [DW-1:0] m_bits;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic model_hv();
        if (exp_q.size() == 0) return 1'b0;
        return !(exp_q[0].op == 1'b0 && (m_pend || m_full));
    endfunction

    // One clock cycle: drive at negedge, check combinational outputs, then advance the model.
    task automatic cyc(input logic rst, input logic rv, input logic op, input logic [AW-1:0] addr,
                       input logic [DW-1:0] val, input logic deq, input logic sv,
                       input logic [DW-1:0] sd, input logic rdy);
        logic exp_acc;
        logic emp;
        ent_t hd;
        @(negedge clock);
        reset           = rst;
        dpi_req_valid   = rv;
        dpi_req_opcode  = op;
        dpi_req_addr    = addr;
        dpi_req_value   = val;
        host_req_deq    = deq;
        host_resp_valid = sv;
        host_resp_bits  = sd;
        dpi_resp_ready  = rdy;
        #1;
        emp     = (exp_q.size() == 0);
        exp_acc = rv && (exp_q.size() != DEPTH) && !rst;
        hd      = emp ? '{1'b0, '0, '0} : exp_q[0];
        chk("req_deq", 64'(dpi_req_deq), 64'(exp_acc));
        chk("host_valid", 64'(host_req_valid), 64'(model_hv()));
        chk("host_op", 64'(host_req_opcode), 64'(hd.op));
        chk("host_addr", 64'(host_req_addr), 64'(hd.addr));
        chk("host_value", 64'(host_req_value), 64'(hd.val));
        chk("resp_valid", 64'(dpi_resp_valid), 64'(m_full));
        chk("resp_bits", 64'(dpi_resp_bits), 64'(m_bits));
        if (rst) begin
            exp_q.delete();
            resp_q.delete();
            m_pend = 1'b0;
            m_full = 1'b0;
            m_bits = '0;
        end else begin
            if (m_full && rdy) begin
                if (resp_q.size() == 0) chk("resp_sb_empty", 64'd1, 64'd0);
                else chk("resp_sb", 64'(dpi_resp_bits), 64'(resp_q.pop_front()));
                m_full = 1'b0;
            end
            if (sv && m_pend) begin
                m_bits = sd;
                m_full = 1'b1;
                resp_q.push_back(sd);
            end
            if (sv) m_pend = 1'b0;
            if (deq && !emp) begin
                if (hd.op == 1'b0) m_pend = 1'b1;
                void'(exp_q.pop_front());
            end
            if (exp_acc) exp_q.push_back('{op, addr, val});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, '0, 0, 0, '0, 0);
    endtask

    task automatic enq(input logic op, input logic [AW-1:0] addr, input logic [DW-1:0] val);
        cyc(0, 1, op, addr, val, 0, 0, '0, 0);
    endtask

    task automatic deq1();
        cyc(0, 0, 0, '0, '0, 1, 0, '0, 0);
    endtask

    task automatic resp(input logic [DW-1:0] d);
        cyc(0, 0, 0, '0, '0, 0, 1, d, 0);
    endtask

    task automatic ready1();
        cyc(0, 0, 0, '0, '0, 0, 0, '0, 1);
    endtask

    initial begin
        m_pend = 1'b0;
        m_full = 1'b0;
        m_bits = '0;
        // Reset with a request presented: nothing may be accepted or offered.
        cyc(1, 1, 1, 8'h55, 32'h1234, 0, 0, '0, 0);
        cyc(1, 1, 1, 8'h55, 32'h1234, 0, 0, '0, 0);

        // Single write
        enq(1, 8'h10, 32'hDEADBEEF);
        idle(2);
        deq1();
        idle(1);

        // Fill and overflow
        for (int i = 0; i < 4; i++) enq(1, 8'(8'h20 + i), 32'(32'hA0 + i));
        enq(1, 8'h24, 32'hA4);
        cyc(0, 1, 1, 8'h24, 32'hA4, 1, 0, '0, 0);
        enq(1, 8'h24, 32'hA4);
        for (int i = 0; i < 4; i++) deq1();
        idle(1);

        // Deq while empty is ignored
        deq1();
        idle(1);

        // Read round trip
        enq(0, 8'h14, '0);
        idle(1);
        deq1();
        idle(2);
        resp(32'h7);
        idle(2);
        ready1();
        idle(1);

        // Read throttle
        enq(0, 8'h18, '0);
        enq(0, 8'h1C, '0);
        deq1();
        idle(1);
        resp(32'h11);
        idle(3);
        ready1();
        deq1();
        idle(1);
        resp(32'h22);
        ready1();
        idle(1);

        // Stray response: held RVALID on the second cycle must be ignored
        enq(0, 8'h30, '0);
        deq1();
        resp(32'hAA);
        resp(32'hBB);
        idle(1);
        ready1();
        idle(1);

        // Writes pass a blocked read's position only in order
        enq(1, 8'h40, 32'h1);
        enq(0, 8'h41, '0);
        enq(1, 8'h42, 32'h2);
        deq1();
        deq1();
        idle(1);
        resp(32'h33);
        idle(1);
        ready1();
        deq1();
        idle(1);

        // Reset mid-operation with a read pending and three entries queued
        enq(0, 8'h50, '0);
        deq1();
        enq(1, 8'h51, 32'h5);
        enq(1, 8'h52, 32'h6);
        enq(0, 8'h53, '0);
        cyc(1, 0, 0, '0, '0, 0, 0, '0, 0);
        resp(32'hEE);
        idle(2);

        // Protocol-compliant random traffic
        for (int i = 0; i < 400; i++) begin
            logic rv, op, dq, sv, rdy;
            rv  = ($urandom_range(0, 2) != 0);
            op  = $urandom_range(0, 1);
            dq  = model_hv() && ($urandom_range(0, 2) != 0);
            sv  = m_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 1) != 0);
            cyc(0, rv, op, AW'($urandom), DW'($urandom), dq, sv, DW'($urandom), rdy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
